// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF         = 2'b00;
    localparam logic [1:0] FWD_M          = 2'b10;
    localparam logic [1:0] FWD_W          = 2'b01;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one Execute-stage source register.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic [REG_W-1:0] rd_w_i,
    input  logic             regwrite_m_i,
    input  logic             regwrite_w_i,
    output logic [1:0]       fwd_o
);

    // Memory stage has priority over writeback; x0 never forwards.
    always_comb begin
        fwd_o = FWD_RF;
        if (regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush,
// memory-wait freeze with watchdog, and performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1_D,
    input  logic [REG_W-1:0] Rs2_D,
    input  logic [REG_W-1:0] Rs1_E,
    input  logic [REG_W-1:0] Rs2_E,
    input  logic [REG_W-1:0] RD_E,
    input  logic [REG_W-1:0] RD_M,
    input  logic [REG_W-1:0] RD_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic             MemAccess_M,
    input  logic             mem_ready,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic             mem_err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                mem_err_q;
    logic [CNT_W-1:0]    cyc_cnt_q, stall_cnt_q, flush_cnt_q;
    logic [1:0]          fwd_a_c, fwd_b_c;
    logic                mem_hold_c, freeze_c, lw_c, lwe_c;

    fwd_sel u_fwd_a (
        .rs_i         (Rs1_E),
        .rd_m_i       (RD_M),
        .rd_w_i       (RD_W),
        .regwrite_m_i (RegWrite_M),
        .regwrite_w_i (RegWrite_W),
        .fwd_o        (fwd_a_c)
    );

    fwd_sel u_fwd_b (
        .rs_i         (Rs2_E),
        .rd_m_i       (RD_M),
        .rd_w_i       (RD_W),
        .regwrite_m_i (RegWrite_M),
        .regwrite_w_i (RegWrite_W),
        .fwd_o        (fwd_b_c)
    );

    // Hazard detection; a taken branch squashes the dependent instruction.
    always_comb begin
        mem_hold_c = MemAccess_M & ~mem_ready;
        freeze_c   = (state_q == ERR) | mem_hold_c;
        lw_c       = (ResultSrc_E == RESULTSRC_LOAD) && (RD_E != '0) &&
                     ((RD_E == Rs1_D) || (RD_E == Rs2_D));
        lwe_c      = lw_c & ~PCSrc_E;
    end

    // Mealy control outputs; reset forces bubbles everywhere and no stalls.
    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Stall_M    = 1'b0;
        Flush_D    = 1'b1;
        Flush_E    = 1'b1;
        Flush_W    = 1'b1;
        if (rst_n) begin
            ForwardA_E = fwd_a_c;
            ForwardB_E = fwd_b_c;
            if (freeze_c) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_D = 1'b0;
                Flush_E = 1'b0;
                Flush_W = 1'b1;
            end else begin
                Stall_F = lwe_c;
                Stall_D = lwe_c;
                Flush_D = PCSrc_E;
                Flush_E = lwe_c | PCSrc_E;
                Flush_W = 1'b0;
            end
        end
    end

    // Memory-wait state machine and watchdog counter next state.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (mem_hold_c) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(MAX_WAIT)) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // State, sticky error and free-running counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= (state_d == ERR);
            cyc_cnt_q   <= cyc_cnt_q + CNT_W'(1);
            stall_cnt_q <= stall_cnt_q + CNT_W'(Stall_F);
            if (PCSrc_E && !freeze_c) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_err   = mem_err_q;
    assign cyc_cnt   = cyc_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic        RegWrite_M, RegWrite_W;
    logic [1:0]  ResultSrc_E;
    logic        PCSrc_E, MemAccess_M, mem_ready;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        Stall_F, Stall_D, Stall_E, Stall_M;
    logic        Flush_D, Flush_E, Flush_W, mem_err;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_cyc = 0, exp_stall = 0, exp_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32), .MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .MemAccess_M(MemAccess_M), .mem_ready(mem_ready),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .mem_err(mem_err), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic clear_inputs();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
        RD_E = 0; RD_M = 0; RD_W = 0;
        RegWrite_M = 0; RegWrite_W = 0; ResultSrc_E = 2'b00;
        PCSrc_E = 0; MemAccess_M = 0; mem_ready = 0;
    endtask

    // Advance one clock edge and account for the expected counter increments.
    task automatic tick(input bit st, input bit fl);
        @(posedge clk);
        #1;
        exp_cyc   = exp_cyc + 1;
        exp_stall = exp_stall + 32'(st);
        exp_flush = exp_flush + 32'(fl);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        n_total++; if ({Flush_D, Flush_E, Flush_W} !== 3'b111) $display("FAIL rst_flush got %b want 111", {Flush_D, Flush_E, Flush_W}); else n_pass++;
        n_total++; if ({Stall_F, Stall_D, Stall_E, Stall_M} !== 4'b0000) $display("FAIL rst_stall got %b want 0000", {Stall_F, Stall_D, Stall_E, Stall_M}); else n_pass++;
        n_total++; if ({ForwardA_E, ForwardB_E} !== 4'b0000) $display("FAIL rst_fwd got %b want 0000", {ForwardA_E, ForwardB_E}); else n_pass++;
        n_total++; if ({cyc_cnt, stall_cnt, flush_cnt} !== 96'd0 || mem_err !== 1'b0) $display("FAIL rst_cnt got %0d %0d %0d err %b want 0", cyc_cnt, stall_cnt, flush_cnt, mem_err); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0);
        n_total++; if (cyc_cnt !== 32'd1) $display("FAIL rst_first_cyc got %0d want 1", cyc_cnt); else n_pass++;
        n_total++; if ({Flush_D, Flush_E, Flush_W} !== 3'b000) $display("FAIL run_idle_flush got %b want 000", {Flush_D, Flush_E, Flush_W}); else n_pass++;
    endtask

    task automatic test_forwarding();
        RD_M = 5; RegWrite_M = 1; RD_W = 5; RegWrite_W = 1; Rs1_E = 5; Rs2_E = 5;
        #1;
        n_total++; if (ForwardA_E !== 2'b10) $display("FAIL fwd_a_m got %b want 10", ForwardA_E); else n_pass++;
        n_total++; if (ForwardB_E !== 2'b10) $display("FAIL fwd_b_m got %b want 10", ForwardB_E); else n_pass++;
        RD_M = 0;
        #1;
        n_total++; if (ForwardA_E !== 2'b01) $display("FAIL fwd_a_w got %b want 01", ForwardA_E); else n_pass++;
        RD_M = 5; Rs1_E = 0;
        #1;
        n_total++; if (ForwardA_E !== 2'b00) $display("FAIL fwd_a_x0 got %b want 00", ForwardA_E); else n_pass++;
        RegWrite_M = 0;
        #1;
        n_total++; if (ForwardB_E !== 2'b01) $display("FAIL fwd_b_nowe_m got %b want 01", ForwardB_E); else n_pass++;
        RegWrite_W = 0;
        #1;
        n_total++; if (ForwardB_E !== 2'b00) $display("FAIL fwd_b_none got %b want 00", ForwardB_E); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_load_use();
        ResultSrc_E = 2'b01; RD_E = 7; Rs1_D = 3; Rs2_D = 7;
        #1;
        n_total++; if ({Stall_F, Stall_D, Flush_E, Flush_D} !== 4'b1110) $display("FAIL lu_ctrl got %b want 1110", {Stall_F, Stall_D, Flush_E, Flush_D}); else n_pass++;
        n_total++; if ({Stall_E, Stall_M, Flush_W} !== 3'b000) $display("FAIL lu_back got %b want 000", {Stall_E, Stall_M, Flush_W}); else n_pass++;
        tick(1, 0);
        // The load has moved on and a bubble now sits in Execute.
        ResultSrc_E = 2'b00; RD_E = 0;
        #1;
        n_total++; if ({Stall_F, Stall_D, Flush_E} !== 3'b000) $display("FAIL lu_release got %b want 000", {Stall_F, Stall_D, Flush_E}); else n_pass++;
        n_total++; if (stall_cnt !== exp_stall) $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        ResultSrc_E = 2'b01; RD_E = 0; Rs1_D = 0; Rs2_D = 0;
        #1;
        n_total++; if (Stall_F !== 1'b0) $display("FAIL lu_x0 got %b want 0", Stall_F); else n_pass++;
        ResultSrc_E = 2'b10; RD_E = 7; Rs2_D = 7;
        #1;
        n_total++; if (Stall_F !== 1'b0) $display("FAIL lu_not_load got %b want 0", Stall_F); else n_pass++;
        clear_inputs();
        tick(0, 0);
    endtask

    task automatic test_branch();
        ResultSrc_E = 2'b01; RD_E = 7; Rs1_D = 7; PCSrc_E = 1;
        #1;
        n_total++; if ({Flush_D, Flush_E, Stall_F, Stall_D} !== 4'b1100) $display("FAIL br_lu got %b want 1100", {Flush_D, Flush_E, Stall_F, Stall_D}); else n_pass++;
        tick(0, 1);
        clear_inputs();
        #1;
        n_total++; if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) $display("FAIL br_cnt got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); else n_pass++;
    endtask

    task automatic test_mem_wait();
        MemAccess_M = 1; mem_ready = 0; PCSrc_E = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_W, Flush_D, Flush_E} !== 7'b1111100) $display("FAIL mw_freeze cyc %0d got %b want 1111100", i, {Stall_F, Stall_D, Stall_E, Stall_M, Flush_W, Flush_D, Flush_E}); else n_pass++;
            tick(1, 0);
        end
        mem_ready = 1;
        #1;
        n_total++; if ({Stall_F, Stall_D, Stall_E, Stall_M, Flush_W, Flush_D} !== 6'b000001) $display("FAIL mw_release got %b want 000001", {Stall_F, Stall_D, Stall_E, Stall_M, Flush_W, Flush_D}); else n_pass++;
        tick(0, 1);
        clear_inputs();
        #1;
        n_total++; if (stall_cnt !== exp_stall || flush_cnt !== exp_flush || cyc_cnt !== exp_cyc) $display("FAIL mw_cnt got %0d/%0d/%0d want %0d/%0d/%0d", stall_cnt, flush_cnt, cyc_cnt, exp_stall, exp_flush, exp_cyc); else n_pass++;
        n_total++; if (mem_err !== 1'b0) $display("FAIL mw_no_err got %b want 0", mem_err); else n_pass++;
    endtask

    task automatic test_watchdog();
        MemAccess_M = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (mem_err !== 1'b0 || Stall_F !== 1'b1) $display("FAIL wd_pre cyc %0d got err %b stall %b want 0 1", i, mem_err, Stall_F); else n_pass++;
            tick(1, 0);
        end
        n_total++; if (mem_err !== 1'b1) $display("FAIL wd_err got %b want 1", mem_err); else n_pass++;
        MemAccess_M = 0; mem_ready = 1; PCSrc_E = 1;
        #1;
        n_total++; if ({Stall_F, Stall_M, Flush_W, Flush_D} !== 4'b1110) $display("FAIL wd_hold got %b want 1110", {Stall_F, Stall_M, Flush_W, Flush_D}); else n_pass++;
        tick(1, 0);
        n_total++; if (mem_err !== 1'b1 || flush_cnt !== exp_flush) $display("FAIL wd_sticky got err %b flush %0d want 1 %0d", mem_err, flush_cnt, exp_flush); else n_pass++;
        rst_n = 1'b0;
        #1;
        exp_cyc = 0; exp_stall = 0; exp_flush = 0;
        n_total++; if ({cyc_cnt, stall_cnt, flush_cnt} !== 96'd0 || mem_err !== 1'b0 || Stall_F !== 1'b0) $display("FAIL wd_rst got %0d %0d %0d err %b stall %b want 0", cyc_cnt, stall_cnt, flush_cnt, mem_err, Stall_F); else n_pass++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0);
        n_total++; if (Stall_F !== 1'b0 || Flush_W !== 1'b0 || cyc_cnt !== 32'd1) $display("FAIL wd_run got stall %b flush_w %b cyc %0d want 0 0 1", Stall_F, Flush_W, cyc_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        MemAccess_M = 1; mem_ready = 0;
        tick(1, 0);
        tick(1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if ({Stall_F, Stall_D, Stall_E, Stall_M} !== 4'b0000 || {Flush_D, Flush_E, Flush_W} !== 3'b111) $display("FAIL rmw_out got %b %b want 0000 111", {Stall_F, Stall_D, Stall_E, Stall_M}, {Flush_D, Flush_E, Flush_W}); else n_pass++;
        n_total++; if (cyc_cnt !== 32'd0 || stall_cnt !== 32'd0) $display("FAIL rmw_cnt got %0d %0d want 0 0", cyc_cnt, stall_cnt); else n_pass++;
        exp_cyc = 0; exp_stall = 0; exp_flush = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0);
        n_total++; if (cyc_cnt !== exp_cyc || mem_err !== 1'b0 || Stall_F !== 1'b0) $display("FAIL rmw_run got cyc %0d err %b stall %b want %0d 0 0", cyc_cnt, mem_err, Stall_F, exp_cyc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_watchdog();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
